lif_sweep_seq: RTL

LIF_SWEEP_SEQ -- requirements
Module: lif_sweep_seq

---
 rtl/lif_sweep_seq.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/lif_sweep_seq.sv
// lif_sweep_seq: sequential leaky integrate-and-fire update of N neurons.
// One neuron is read, integrated, thresholded and written back per cycle.
// Host voltage writes take priority and stall the sweep for that cycle.
module lif_sweep_seq #(
    parameter int                 N          = 32,
    parameter int                 LEAK_SHIFT = 3,
    parameter logic signed [31:0] V_RESET    = 32'sd0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic [4:0]         ra,
    input  logic signed [31:0] cur_in,
    input  logic signed [31:0] vol_in,
    input  logic signed [31:0] vt_in,
    output logic               vol_we,
    output logic [4:0]         vol_wa,
    output logic [31:0]        vol_wd,
    input  logic               host_req,
    input  logic [4:0]         host_wa,
    input  logic [31:0]        host_wd,
    output logic               host_gnt,
    output logic [31:0]        spike_vec,
    output logic [5:0]         spike_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [4:0] LAST_IDX = 5'(N - 1);

    // Clamp a 34-bit intermediate into the signed 32-bit range.
    function automatic logic [31:0] sat32(input logic [33:0] x);
        logic [31:0] r;
        if ((x[33:31] == 3'b000) || (x[33:31] == 3'b111)) begin
            r = x[31:0];
        end else if (x[33]) begin
            r = 32'h8000_0000;
        end else begin
            r = 32'h7FFF_FFFF;
        end
        return r;
    endfunction

    state_t      state_q;
    logic [4:0]  idx_q;
    logic        busy_q;
    logic        done_q;
    logic [31:0] spike_vec_q;
    logic [5:0]  spike_cnt_q;

    logic signed [31:0] leak_d;
    logic [33:0]        sum_d;
    logic [31:0]        v_new_d;
    logic               fire_d;
    logic               host_ok_d;
    logic               step_d;

    // Neuron update datapath and sweep-step qualification.
    always_comb begin
        leak_d    = vol_in >>> LEAK_SHIFT;
        sum_d     = {{2{vol_in[31]}}, vol_in} - {{2{leak_d[31]}}, leak_d}
                  + {{2{cur_in[31]}}, cur_in};
        v_new_d   = sat32(sum_d);
        fire_d    = ($signed(v_new_d) >= vt_in);
        host_ok_d = host_req & ~rst;
        step_d    = (state_q == RUN) & ~host_req & ~rst;
    end

    // Register-file port drive: host write wins, otherwise the sweep writes.
    always_comb begin
        ra       = (state_q == RUN) ? idx_q : 5'd0;
        host_gnt = host_ok_d;
        if (host_ok_d) begin
            vol_we = 1'b1;
            vol_wa = host_wa;
            vol_wd = host_wd;
        end else if (step_d) begin
            vol_we = 1'b1;
            vol_wa = idx_q;
            vol_wd = fire_d ? V_RESET : v_new_d;
        end else begin
            vol_we = 1'b0;
            vol_wa = 5'd0;
            vol_wd = 32'h0000_0000;
        end
    end

    // Sweep controller FSM with registered status and spike outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= 5'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            spike_vec_q <= 32'h0000_0000;
            spike_cnt_q <= 6'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q     <= RUN;
                        idx_q       <= 5'd0;
                        busy_q      <= 1'b1;
                        spike_vec_q <= 32'h0000_0000;
                        spike_cnt_q <= 6'd0;
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                RUN: begin
                    // A host write this cycle owns the write port: hold position.
                    if (!host_req) begin
                        if (fire_d) begin
                            spike_vec_q[idx_q] <= 1'b1;
                            spike_cnt_q        <= spike_cnt_q + 6'd1;
                        end
                        if (idx_q == LAST_IDX) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            idx_q   <= 5'd0;
                        end else begin
                            idx_q <= idx_q + 5'd1;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    idx_q   <= 5'd0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign spike_vec = spike_vec_q;
    assign spike_cnt = spike_cnt_q;

endmodule
